// File: rtl/if_stage_pkg.sv
// Shared definitions for the fetch stage and its consumer (id_stage).
//  - NOP_INSN : canonical no-op (addi x0,x0,0), shown on id_ir when idle or faulted
//  - state_t  : fetch state, S_RUN issues requests, S_FAULT parks after a bad redirect
//  - if_id_t  : {misaligned, pc, ir} bundle carried from fetch to decode
//  - IF_ID_W  : bit width of if_id_t, shared with id_stage
package if_stage_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FAULT = 1'b1
  } state_t;

  typedef struct packed {
    logic        misaligned;
    logic [31:0] pc;
    logic [31:0] ir;
  } if_id_t;

  localparam int IF_ID_W = $bits(if_id_t);

  // Entry presented to decode when a redirect target is not word aligned.
  function automatic if_id_t make_fault_entry(input logic [31:0] pc);
    if_id_t e;
    e.misaligned = 1'b1;
    e.pc         = pc;
    e.ir         = NOP_INSN;
    return e;
  endfunction

  // Entry for a normally fetched instruction word.
  function automatic if_id_t make_insn_entry(input logic [31:0] pc, input logic [31:0] ir);
    if_id_t e;
    e.misaligned = 1'b0;
    e.pc         = pc;
    e.ir         = ir;
    return e;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Small synchronous FIFO with a combinational head read.
//  clk, rst   : clock and synchronous active-high clear
//  flush      : empties the FIFO; a push in the same cycle becomes the only entry
//  push       : write push_data (caller guarantees not full)
//  pop        : drop head (caller guarantees not empty; ignored during flush)
//  head       : oldest entry, valid while count != 0
//  count      : number of stored entries, 0..DEPTH
module if_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [AW-1:0]    wr_idx;

  // A flush rewinds both pointers, so a push in the flush cycle lands in slot 0.
  assign wr_idx = flush ? '0 : wr_ptr_reg;

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= push ? AW'(1) : '0;
      count_reg  <= push ? CW'(1) : '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage.
// Issues sequential word fetches on a req/gnt/rvalid instruction-memory port,
// buffers returned words and hands {ir, pc, misaligned} to decode with valid/ready.
// A redirect squashes everything in flight and buffered and restarts at redirect_pc;
// a misaligned target parks the stage and delivers a single fault entry instead.
//  clk, rst                         : clock, synchronous active-high reset
//  redirect, redirect_pc            : restart request and target address
//  imem_req, imem_addr, imem_gnt    : fetch request channel
//  imem_rvalid, imem_rdata          : in-order fetch response channel
//  id_valid, id_ready               : handshake towards decode
//  id_ir, id_pc, id_misaligned      : instruction bundle towards decode
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_ir,
  output logic [31:0] id_pc,
  output logic        id_misaligned
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t      state_reg;
  logic [31:0] pc_reg;
  // outstanding counts every request still awaiting its response, including
  // those already marked for discard; kill counts the ones to discard.
  logic [CW-1:0] outstanding_reg;
  logic [CW-1:0] kill_reg;

  logic [CW-1:0] q_count;
  logic [CW-1:0] pcf_count;
  logic [31:0]   pcf_head;
  if_id_t        q_head;
  if_id_t        q_in;

  logic          resp;
  logic          live_resp;
  logic          issue;
  logic          flush;
  logic          fault_push;
  logic [CW:0]   occupancy;
  logic [CW-1:0] outstanding_dec;
  logic [CW-1:0] squash_cnt;

  // A response with nothing outstanding cannot be ours; ignoring it keeps the
  // counters from wrapping.
  assign resp            = imem_rvalid && (outstanding_reg != '0);
  assign outstanding_dec = outstanding_reg - CW'(resp);
  // Everything still in flight after this cycle must be dropped on a squash.
  // The range guard only matters for the very first reset after power-up.
  assign squash_cnt      = (outstanding_dec <= CW'(DEPTH)) ? outstanding_dec : '0;

  // Reserve a queue slot for every request before issuing it, so a live
  // response always finds room.
  assign occupancy = {1'b0, outstanding_reg} + {1'b0, q_count};
  assign imem_req  = !rst && (state_reg == S_RUN) && !redirect &&
                     (occupancy < (CW+1)'(DEPTH));
  assign imem_addr = pc_reg;
  assign issue     = imem_req && imem_gnt;

  assign flush      = rst || redirect;
  assign live_resp  = resp && (kill_reg == '0) && !flush && (pcf_count != '0);
  assign fault_push = !rst && redirect && (redirect_pc[1:0] != 2'b00);

  always_comb begin
    q_in = make_insn_entry(pcf_head, imem_rdata);
    if (redirect) begin
      q_in = make_fault_entry(redirect_pc);
    end
  end

  // Addresses of issued requests, matched to responses in issue order.
  if_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_pc_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (issue),
    .push_data (pc_reg),
    .pop       (live_resp),
    .head      (pcf_head),
    .count     (pcf_count)
  );

  // Instructions waiting for decode.
  if_fifo #(
    .WIDTH (IF_ID_W),
    .DEPTH (DEPTH)
  ) u_insn_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (live_resp || fault_push),
    .push_data (q_in),
    .pop       (id_valid && id_ready),
    .head      (q_head),
    .count     (q_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg          <= RESET_PC;
      state_reg       <= S_RUN;
      outstanding_reg <= squash_cnt;
      kill_reg        <= squash_cnt;
    end else if (redirect) begin
      outstanding_reg <= squash_cnt;
      kill_reg        <= squash_cnt;
      if (redirect_pc[1:0] == 2'b00) begin
        pc_reg    <= redirect_pc;
        state_reg <= S_RUN;
      end else begin
        state_reg <= S_FAULT;
      end
    end else begin
      outstanding_reg <= outstanding_reg + CW'(issue) - CW'(resp);
      if (resp && (kill_reg != '0)) begin
        kill_reg <= kill_reg - CW'(1);
      end
      if (issue) begin
        pc_reg <= pc_reg + 32'd4;
      end
    end
  end

  // Outputs come straight from the queue head; idle value is a NOP at pc 0.
  assign id_valid = (q_count != '0);

  always_comb begin
    id_ir         = NOP_INSN;
    id_pc         = '0;
    id_misaligned = 1'b0;
    if (id_valid) begin
      id_ir         = q_head.ir;
      id_pc         = q_head.pc;
      id_misaligned = q_head.misaligned;
    end
  end

endmodule
